// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide unit that produces the HI/LO pair.
//   mult (op=0): Booth radix-2, 32 iterations, {hi,lo} = a*b (signed, full width).
//   div  (op=1): restoring division on magnitudes, 32 iterations,
//                lo = quotient and hi = remainder, both truncated toward zero.
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start, op, a, b       request, operation select and operands (all sampled in IDLE)
//   hi, lo                result pair; these hold their value between operations
//   busy                  high while iterating (RUN)
//   done                  one-cycle pulse (DONE)
//   div_zero              divide-by-zero flag for the last accepted operation
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6     // must satisfy 2**CNT_W > WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     acc_q, acc_d;        // mult: Booth accumulator; div: partial remainder
    logic [WIDTH-1:0]   q_q, q_d;            // mult: multiplier; div: dividend -> quotient
    logic               qm1_q, qm1_d;        // Booth q_-1 bit
    logic [WIDTH-1:0]   m_q, m_d;            // mult: multiplicand; div: divisor magnitude
    logic               op_q, op_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div_zero_q, div_zero_d;
    logic               busy_q, busy_d, done_q, done_d;

    // One iteration of either algorithm, computed from the current registers.
    logic [WIDTH:0]     booth_sum, div_shift, div_trial;
    logic [WIDTH:0]     iter_acc;
    logic [WIDTH-1:0]   iter_q;
    logic               iter_qm1;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_res, rem_res;

    // The accumulator is one bit wider than the operands so that subtracting
    // a multiplicand of -2^(WIDTH-1) cannot overflow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        booth_sum = acc_q;
        unique case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
            default: booth_sum = acc_q;
        endcase

        // The shifted remainder is below 2^WIDTH, so bit WIDTH of the trial
        // subtraction is set exactly when the divisor does not fit.
        div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, m_q};

        iter_acc = acc_q;
        iter_q   = q_q;
        iter_qm1 = qm1_q;
        if (!op_q) begin
            iter_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            iter_q   = {booth_sum[0], q_q[WIDTH-1:1]};
            iter_qm1 = q_q[0];
        end else if (div_trial[WIDTH]) begin
            iter_acc = div_shift;
            iter_q   = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            iter_acc = div_trial;
            iter_q   = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    // The magnitude of -2^(WIDTH-1) is representable as an unsigned WIDTH-bit value.
    assign a_mag   = a[WIDTH-1] ? -a : a;
    assign b_mag   = b[WIDTH-1] ? -b : b;
    assign quo_res = quo_neg_q ? -iter_q : iter_q;
    assign rem_res = rem_neg_q ? -iter_acc[WIDTH-1:0] : iter_acc[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        op_d       = op_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    if (op && (b == '0)) begin
                        // Divide by zero: skip the schedule and leave hi/lo untouched.
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        div_zero_d = 1'b0;
                        state_d    = S_RUN;
                        if (!op) begin
                            m_d = a;
                            q_d = b;
                        end else begin
                            m_d       = b_mag;
                            q_d       = a_mag;
                            quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                            rem_neg_d = a[WIDTH-1];
                        end
                    end
                end
            end
            S_RUN: begin
                acc_d = iter_acc;
                q_d   = iter_q;
                qm1_d = iter_qm1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    if (!op_q) begin
                        hi_d = iter_acc[WIDTH-1:0];
                        lo_d = iter_q;
                    end else begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            op_q       <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            op_q       <= op_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule
